hazard_control_unit: RTL



---
 rtl/hazard_control_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use stalls, branch squashes, dmem wait/timeout.
// Define HAZARD_PERF_CNT_EN to build the saturating performance counters.
module hazard_control_unit #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_if_id,
   input  logic [4:0]       rs2_if_id,
   input  logic             use_rs1_if_id,
   input  logic             use_rs2_if_id,
   input  logic [4:0]       rd_id_ex,
   input  logic             mem_read_id_ex,
   input  logic             branch_taken_ex,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             mem_wb_bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] load_use_events,
   output logic [CNT_W-1:0] flush_events
);

   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ERR  = 2'd2;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   logic [1:0] state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       mem_stall;
   logic       freeze;
   logic       lu;

   assign mem_stall = dmem_req & ~dmem_ready;
   assign freeze    = mem_stall | (state_q == S_ERR);

   assign lu = mem_read_id_ex & (rd_id_ex != 5'd0) &
               ((use_rs1_if_id & (rd_id_ex == rs1_if_id)) |
                (use_rs2_if_id & (rd_id_ex == rs2_if_id)));

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         S_RUN: begin
            if (mem_stall) begin
               state_d = S_WAIT;
               wait_d  = 8'd1;
            end
         end
         S_WAIT: begin
            if (dmem_ready) begin
               state_d = S_RUN;
               wait_d  = 8'd0;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_ERR;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_RUN;
            wait_d  = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Priority: reset > freeze > branch > load-use > run
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_write  = 1'b1;
      mem_wb_bubble = 1'b0;
      if (rst) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         mem_wb_bubble = 1'b1;
      end else if (freeze) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (branch_taken_ex) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (lu) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   assign mem_timeout = (state_q == S_ERR) & ~rst;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, lu_q, fl_q;
   logic             lu_ev, fl_ev;

   assign lu_ev = ~freeze & ~branch_taken_ex & lu;
   assign fl_ev = ~freeze & branch_taken_ex;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         lu_q    <= '0;
         fl_q    <= '0;
      end else begin
         if (~pc_write && ~&stall_q) stall_q <= stall_q + 1'b1;
         if (lu_ev && ~&lu_q)        lu_q    <= lu_q + 1'b1;
         if (fl_ev && ~&fl_q)        fl_q    <= fl_q + 1'b1;
      end
   end

   assign stall_cycles    = stall_q;
   assign load_use_events = lu_q;
   assign flush_events    = fl_q;
`else
   assign stall_cycles    = '0;
   assign load_use_events = '0;
   assign flush_events    = '0;
`endif

endmodule
